// File: rtl/aes_input_packer_pkg.sv
// ---------------------------------------------------------------------------
// aes_input_packer_pkg
// Shared definitions for the AES input packer. These include the issue FSM
// state encoding, the block geometry (4 x 32-bit words = 128 bits), and the
// default hold period for each block at the core input (one key-schedule
// sweep).
// ---------------------------------------------------------------------------
package aes_input_packer_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int BLK_W          = 128;
  localparam int WORDS_PER_BLK  = 4;
  localparam int BLK_PERIOD_DEF = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

endpackage : aes_input_packer_pkg

// File: rtl/aes_input_packer_if.sv
// ---------------------------------------------------------------------------
// aes_input_packer_if
// Upstream plaintext word stream using a valid/ready handshake.
//   s_valid : producer has a word on s_data
//   s_ready : packer can take a word this cycle
//   s_data  : plaintext word; the first word of a block is bits [127:96]
// modport master : the word producer
// modport slave  : the packer
// ---------------------------------------------------------------------------
interface aes_input_packer_if #(
  parameter int WORD_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface : aes_input_packer_if

// File: rtl/aes_input_packer_blk_fifo2.sv
// ---------------------------------------------------------------------------
// blk_fifo2
// Two-entry, 128-bit block FIFO. A push and a pop in the same cycle are both
// honoured. A push while full and a pop while empty are ignored.
//   clk, rst     : clock and asynchronous active-low reset
//   push_i/_data : write one block
//   pop_i        : drop the head block
//   full_o       : two blocks held
//   empty_o      : no block held
//   head_o       : oldest block
//   next_o       : second-oldest block (valid only when full_o)
// ---------------------------------------------------------------------------
module blk_fifo2
  import aes_input_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [BLK_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [BLK_W-1:0] head_o,
  output logic [BLK_W-1:0] next_o
);

  logic [BLK_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[~rd_ptr_q];

  // NOTE: storage is deliberately left out of reset. The occupancy count
  // guards every read, so the storage contents after reset never matter.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only. As a result,
  // every process sees the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule : blk_fifo2

// File: rtl/aes_input_packer.sv
// ---------------------------------------------------------------------------
// aes_input_packer
// Packs four 32-bit plaintext words into a 128-bit block and queues up to two
// blocks. Each block is then held at the encryption core input for
// BLK_PERIOD cycles. The key is latched only while the packer is idle.
//   clk, rst   : clock and asynchronous active-low reset
//   s_if       : upstream word stream (slave side)
//   key_load   : one-cycle request to latch key_in
//   key_in     : cipher key
//   core_en    : high while a block is presented to the core
//   core_in    : plaintext block to the core
//   core_key   : registered key to the core
//   busy       : FIFO non-empty, partial block, or core_en high
//   key_err    : sticky flag, set when a key_load arrives while busy
// ---------------------------------------------------------------------------
module aes_input_packer
  import aes_input_packer_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int BLK_PERIOD = BLK_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  aes_input_packer_if.slave  s_if,
  input  logic               key_load,
  input  logic [BLK_W-1:0]   key_in,
  output logic               core_en,
  output logic [BLK_W-1:0]   core_in,
  output logic [BLK_W-1:0]   core_key,
  output logic               busy,
  output logic               key_err
);

  localparam int                PCNT_W    = (BLK_PERIOD > 1) ? $clog2(BLK_PERIOD) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(BLK_PERIOD - 1);

  logic [1:0]        wcnt_q, wcnt_d;
  logic [BLK_W-1:0]  asm_q, asm_d;
  logic [PCNT_W-1:0] pcnt_q;
  issue_state_e      state_q;
  logic              core_en_q;
  logic [BLK_W-1:0]  core_in_q;
  logic [BLK_W-1:0]  core_key_q;
  logic              key_err_q;

  logic              xfer;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BLK_W-1:0]  fifo_head;
  logic [BLK_W-1:0]  fifo_next;

  assign s_if.s_ready = !fifo_full;
  assign xfer         = s_if.s_valid && s_if.s_ready;
  assign push         = xfer && (wcnt_q == 2'd3);
  // The block being issued stays at the FIFO head until its period ends.
  // So "full" means that a next block is already waiting behind it.
  assign pop          = (state_q == ISSUE) && (pcnt_q == PCNT_LAST);
  assign busy         = !fifo_empty || (wcnt_q != 2'd0) || core_en_q;

  // NOTE: every always_comb output gets a default first. This keeps the
  // slice insert free of inferred latches.
  always_comb begin
    asm_d  = asm_q;
    wcnt_d = wcnt_q;
    if (xfer) begin
      asm_d[(WORDS_PER_BLK - 1 - int'(wcnt_q)) * WORD_W +: WORD_W] = s_if.s_data;
      wcnt_d = wcnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= 2'd0;
      asm_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      asm_q  <= asm_d;
    end
  end

  blk_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (asm_d),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .next_o      (fifo_next)
  );

  // Issue FSM. core_en and core_in are registered, so they change only at the
  // edge that starts or ends a block period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      core_en_q <= 1'b0;
      core_in_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ISSUE;
            core_en_q <= 1'b1;
            core_in_q <= fifo_head;
            pcnt_q    <= '0;
          end
        end
        ISSUE: begin
          if (pcnt_q == PCNT_LAST) begin
            pcnt_q <= '0;
            if (fifo_full) begin
              core_in_q <= fifo_next;   // back-to-back: core_en stays high
            end else begin
              state_q   <= IDLE;
              core_en_q <= 1'b0;
            end
          end else begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
          end
        end
      endcase
    end
  end

  // A key change is only safe when no block is queued or in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_key_q <= '0;
      key_err_q  <= 1'b0;
    end else if (key_load) begin
      if (!busy) core_key_q <= key_in;
      else       key_err_q  <= 1'b1;
    end
  end

  assign core_en  = core_en_q;
  assign core_in  = core_in_q;
  assign core_key = core_key_q;
  assign key_err  = key_err_q;

endmodule : aes_input_packer
